// File: rtl/sdr_bank_monitor_if.sv
// SDRAM command bus observed by sdr_bank_monitor, together with its status outputs.
// Parameters: NUM_BANKS, BA_W, ERR_CNT_W.
// Signals:
//   sdr_init_done, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_a10 : command side
//   bank_open, viol_valid, viol_code, viol_bank, viol_count                 : monitor side
// Modports: master drives commands and sees status; slave is the monitor.
interface sdr_bank_monitor_if #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BA_W      = 2,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 sdr_init_done;
  logic                 sdr_cs_n;
  logic                 sdr_ras_n;
  logic                 sdr_cas_n;
  logic                 sdr_we_n;
  logic [BA_W-1:0]      sdr_ba;
  logic                 sdr_a10;
  logic [NUM_BANKS-1:0] bank_open;
  logic                 viol_valid;
  logic [2:0]           viol_code;
  logic [BA_W-1:0]      viol_bank;
  logic [ERR_CNT_W-1:0] viol_count;

  modport master (
    output sdr_init_done, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_a10,
    input  bank_open, viol_valid, viol_code, viol_bank, viol_count
  );

  modport slave (
    input  sdr_init_done, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_a10,
    output bank_open, viol_valid, viol_code, viol_bank, viol_count
  );
endinterface

// File: rtl/sdr_bank_monitor.sv
// Passive SDRAM protocol monitor: tracks per-bank state and a global init/refresh
// phase from the command pins, and flags protocol violations with a code.
// Ports:
//   sdram_clk   : clock, rising edge
//   sdram_reset : synchronous active-high reset
//   mon         : sdr_bank_monitor_if.slave (command pins in, bank_open/viol_* out)
// Violation codes: 1 busy bank or refresh in progress, 2 RD/WR/BST to idle bank,
//   3 ACT to non-idle bank, 4 REF/LMR with a bank not idle, 5 illegal command in init.
// Optional feature: define SDR_MON_AUTOPRE_EN so RD/WR with a10=1 to an ACTIVE bank
//   starts an auto-precharge; otherwise a10 is ignored on RD/WR.
module sdr_bank_monitor #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BA_W      = 2,
  parameter int unsigned T_RCD     = 3,
  parameter int unsigned T_RP      = 3,
  parameter int unsigned T_RFC     = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic               sdram_clk,
  input logic               sdram_reset,
  sdr_bank_monitor_if.slave mon
);
  localparam int unsigned BANK_CNT_W = 4;
  localparam int unsigned RFC_CNT_W  = 6;

  typedef enum logic [1:0] {
    BANK_IDLE, BANK_ACTIVATING, BANK_ACTIVE, BANK_PRECHARGING
  } bank_state_e;

  typedef enum logic [1:0] {PH_INIT, PH_RUN, PH_REFRESHING} phase_e;

  // Encoding equals {ras_n,cas_n,we_n} with cs_n low, so decode is a plain cast.
  typedef enum logic [2:0] {
    CMD_LMR, CMD_REF, CMD_PRE, CMD_ACT, CMD_WR, CMD_RD, CMD_BST, CMD_NOP
  } cmd_e;

  bank_state_e               bank_state_q [NUM_BANKS];
  bank_state_e               bank_state_d [NUM_BANKS];
  logic [BANK_CNT_W-1:0]     bank_cnt_q   [NUM_BANKS];
  logic [BANK_CNT_W-1:0]     bank_cnt_d   [NUM_BANKS];
  phase_e                    phase_q, phase_d;
  logic [RFC_CNT_W-1:0]      ref_cnt_q, ref_cnt_d;
  logic [NUM_BANKS-1:0]      bank_open_q;
  logic                      viol_valid_q;
  logic [2:0]                viol_code_q;
  logic [BA_W-1:0]           viol_bank_q;
  logic [ERR_CNT_W-1:0]      viol_count_q;

  cmd_e                      cmd_c;
  bank_state_e               sel_state_c;
  logic                      sel_busy_c;
  logic                      any_not_idle_c;
  logic                      bank_cmd_c;
  logic                      viol_c;
  logic [2:0]                viol_code_c;

  // Command decode and violation classification, lowest code wins.
  always_comb begin
    cmd_c          = mon.sdr_cs_n ? CMD_NOP
                                  : cmd_e'({mon.sdr_ras_n, mon.sdr_cas_n, mon.sdr_we_n});
    sel_state_c    = bank_state_q[mon.sdr_ba];
    any_not_idle_c = 1'b0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (bank_state_q[b] != BANK_IDLE) any_not_idle_c = 1'b1;
    end
    sel_busy_c  = (sel_state_c == BANK_ACTIVATING) || (sel_state_c == BANK_PRECHARGING);
    // PRE-all is not addressed to one bank; it may legally catch activating banks.
    bank_cmd_c  = (cmd_c inside {CMD_ACT, CMD_WR, CMD_RD, CMD_BST}) ||
                  ((cmd_c == CMD_PRE) && !mon.sdr_a10);
    viol_code_c = 3'd0;
    if (((phase_q == PH_REFRESHING) && (cmd_c != CMD_NOP)) || (bank_cmd_c && sel_busy_c))
      viol_code_c = 3'd1;
    else if ((cmd_c inside {CMD_WR, CMD_RD, CMD_BST}) && (sel_state_c == BANK_IDLE))
      viol_code_c = 3'd2;
    else if ((cmd_c == CMD_ACT) && (sel_state_c != BANK_IDLE))
      viol_code_c = 3'd3;
    else if ((cmd_c inside {CMD_REF, CMD_LMR}) && any_not_idle_c)
      viol_code_c = 3'd4;
    else if ((phase_q == PH_INIT) && (cmd_c inside {CMD_ACT, CMD_WR, CMD_RD, CMD_BST}))
      viol_code_c = 3'd5;
    viol_c = (viol_code_c != 3'd0);
  end

  // Next-state: timers always run; command effects only when the command is legal.
  always_comb begin
    phase_d   = phase_q;
    ref_cnt_d = ref_cnt_q;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      bank_state_d[b] = bank_state_q[b];
      bank_cnt_d[b]   = bank_cnt_q[b];
      case (bank_state_q[b])
        BANK_ACTIVATING: begin
          if (bank_cnt_q[b] == '0) bank_state_d[b] = BANK_ACTIVE;
          else bank_cnt_d[b] = bank_cnt_q[b] - BANK_CNT_W'(1);
        end
        BANK_PRECHARGING: begin
          if (bank_cnt_q[b] == '0) bank_state_d[b] = BANK_IDLE;
          else bank_cnt_d[b] = bank_cnt_q[b] - BANK_CNT_W'(1);
        end
        default: ;
      endcase
    end

    case (phase_q)
      PH_INIT: if (mon.sdr_init_done) phase_d = PH_RUN;
      PH_REFRESHING: begin
        if (ref_cnt_q == '0) phase_d = PH_RUN;
        else ref_cnt_d = ref_cnt_q - RFC_CNT_W'(1);
      end
      default: ;
    endcase

    if (!viol_c) begin
      case (cmd_c)
        CMD_ACT: begin
          bank_state_d[mon.sdr_ba] = BANK_ACTIVATING;
          bank_cnt_d[mon.sdr_ba]   = BANK_CNT_W'(T_RCD - 1);
        end
        CMD_PRE: begin
          for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if ((mon.sdr_a10 || (BA_W'(b) == mon.sdr_ba)) &&
                ((bank_state_q[b] == BANK_ACTIVE) || (bank_state_q[b] == BANK_ACTIVATING))) begin
              bank_state_d[b] = BANK_PRECHARGING;
              bank_cnt_d[b]   = BANK_CNT_W'(T_RP - 1);
            end
          end
        end
        CMD_REF: begin
          // REF during init is a legal no-op for the phase machine.
          if (phase_q == PH_RUN) begin
            phase_d   = PH_REFRESHING;
            ref_cnt_d = RFC_CNT_W'(T_RFC - 1);
          end
        end
`ifdef SDR_MON_AUTOPRE_EN
        CMD_WR, CMD_RD: begin
          if (mon.sdr_a10 && (sel_state_c == BANK_ACTIVE)) begin
            bank_state_d[mon.sdr_ba] = BANK_PRECHARGING;
            bank_cnt_d[mon.sdr_ba]   = BANK_CNT_W'(T_RP - 1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      phase_q      <= PH_INIT;
      ref_cnt_q    <= '0;
      bank_open_q  <= '0;
      viol_valid_q <= 1'b0;
      viol_code_q  <= '0;
      viol_bank_q  <= '0;
      viol_count_q <= '0;
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        bank_state_q[b] <= BANK_IDLE;
        bank_cnt_q[b]   <= '0;
      end
    end else begin
      phase_q      <= phase_d;
      ref_cnt_q    <= ref_cnt_d;
      viol_valid_q <= viol_c;
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        bank_state_q[b] <= bank_state_d[b];
        bank_cnt_q[b]   <= bank_cnt_d[b];
        bank_open_q[b]  <= (bank_state_d[b] == BANK_ACTIVE);
      end
      if (viol_c) begin
        viol_code_q <= viol_code_c;
        viol_bank_q <= mon.sdr_ba;
        if (viol_count_q != '1) viol_count_q <= viol_count_q + ERR_CNT_W'(1);
      end
    end
  end

  assign mon.bank_open  = bank_open_q;
  assign mon.viol_valid = viol_valid_q;
  assign mon.viol_code  = viol_code_q;
  assign mon.viol_bank  = viol_bank_q;
  assign mon.viol_count = viol_count_q;
endmodule

// File: tb/tb_sdr_bank_monitor.sv
// Bench for sdr_bank_monitor: directed vector table, hand-written corner sequences and
// randomized commands checked against a cycle-stamp reference model.
module tb_sdr_bank_monitor;
  localparam int unsigned NB        = 4;
  localparam int unsigned BA_W      = 2;
  localparam int unsigned T_RCD     = 3;
  localparam int unsigned T_RP      = 3;
  localparam int unsigned T_RFC     = 8;
  localparam int unsigned ERR_CNT_W = 8;

  typedef enum int {C_NOP, C_LMR, C_REF, C_PRE, C_ACT, C_WR, C_RD, C_BST} cmd_t;

  typedef struct {
    cmd_t       cmd;
    int         ba;
    bit         a10;
    bit         ev;
    int         ecode;
    int         ebank;
    logic [3:0] eopen;
  } vec_t;

  logic sdram_clk = 1'b0;
  logic sdram_reset;
  always #5 sdram_clk = ~sdram_clk;

  sdr_bank_monitor_if #(.NUM_BANKS(NB), .BA_W(BA_W), .ERR_CNT_W(ERR_CNT_W)) bus ();
  sdr_bank_monitor_if #(.NUM_BANKS(NB), .BA_W(BA_W), .ERR_CNT_W(2)) bus_sat ();

  assign bus_sat.sdr_init_done = bus.sdr_init_done;
  assign bus_sat.sdr_cs_n      = bus.sdr_cs_n;
  assign bus_sat.sdr_ras_n     = bus.sdr_ras_n;
  assign bus_sat.sdr_cas_n     = bus.sdr_cas_n;
  assign bus_sat.sdr_we_n      = bus.sdr_we_n;
  assign bus_sat.sdr_ba        = bus.sdr_ba;
  assign bus_sat.sdr_a10       = bus.sdr_a10;

  sdr_bank_monitor #(.NUM_BANKS(NB), .BA_W(BA_W), .T_RCD(T_RCD), .T_RP(T_RP),
                     .T_RFC(T_RFC), .ERR_CNT_W(ERR_CNT_W)) dut (
    .sdram_clk(sdram_clk), .sdram_reset(sdram_reset), .mon(bus));

  sdr_bank_monitor #(.NUM_BANKS(NB), .BA_W(BA_W), .T_RCD(T_RCD), .T_RP(T_RP),
                     .T_RFC(T_RFC), .ERR_CNT_W(2)) dut_sat (
    .sdram_clk(sdram_clk), .sdram_reset(sdram_reset), .mon(bus_sat));

  int checks = 0;
  int failures = 0;

  // Reference model: each bank remembers whether it is logically open and the last
  // edge index at which it is still busy after its most recent ACT/PRE.
  int         cyc;
  bit         opened     [NB];
  int         busy_until [NB];
  int         ref_until;
  bit         init_seen;
  int         m_count, m_count_sat;
  bit         e_valid;
  int         e_code, e_bank;
  logic [3:0] e_open;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int b = 0; b < int'(NB); b++) begin
      opened[b] = 1'b0;
      busy_until[b] = -1;
    end
    ref_until = -1;
    init_seen = 1'b0;
    m_count = 0;
    m_count_sat = 0;
    e_valid = 1'b0;
    e_open = '0;
  endtask

  task automatic model_edge(cmd_t c, int ba, bit a10, bit init);
    bit busy [NB];
    bit idle [NB];
    bit active [NB];
    bit refreshing, in_init, any_not_idle, bank_cmd, c1, c2, c3, c4, c5;
    any_not_idle = 1'b0;
    for (int b = 0; b < int'(NB); b++) begin
      busy[b]   = (cyc <= busy_until[b]);
      idle[b]   = !opened[b] && !busy[b];
      active[b] = opened[b] && !busy[b];
      if (!idle[b]) any_not_idle = 1'b1;
    end
    refreshing = (cyc <= ref_until);
    in_init    = !init_seen;
    bank_cmd   = (c inside {C_ACT, C_RD, C_WR, C_BST}) || (c == C_PRE && !a10);
    c1 = (refreshing && c != C_NOP) || (bank_cmd && busy[ba]);
    c2 = (c inside {C_RD, C_WR, C_BST}) && idle[ba];
    c3 = (c == C_ACT) && !idle[ba];
    c4 = (c inside {C_REF, C_LMR}) && any_not_idle;
    c5 = in_init && (c inside {C_ACT, C_RD, C_WR, C_BST});
    e_valid = c1 || c2 || c3 || c4 || c5;
    if (e_valid) begin
      e_code = c1 ? 1 : c2 ? 2 : c3 ? 3 : c4 ? 4 : 5;
      e_bank = ba;
      if (m_count < (1 << ERR_CNT_W) - 1) m_count++;
      if (m_count_sat < 3) m_count_sat++;
    end else begin
      case (c)
        C_ACT: begin
          opened[ba] = 1'b1;
          busy_until[ba] = cyc + int'(T_RCD);
        end
        C_PRE: begin
          for (int b = 0; b < int'(NB); b++) begin
            if ((a10 || b == ba) && opened[b]) begin
              opened[b] = 1'b0;
              busy_until[b] = cyc + int'(T_RP);
            end
          end
        end
        C_REF: if (!in_init) ref_until = cyc + int'(T_RFC);
`ifdef SDR_MON_AUTOPRE_EN
        C_RD, C_WR: begin
          if (a10 && active[ba]) begin
            opened[ba] = 1'b0;
            busy_until[ba] = cyc + int'(T_RP);
          end
        end
`endif
        default: ;
      endcase
    end
    if (init) init_seen = 1'b1;
    for (int b = 0; b < int'(NB); b++) e_open[b] = opened[b] && (cyc + 1 > busy_until[b]);
    cyc++;
  endtask

  task automatic drive(cmd_t c, int ba, bit a10, bit init);
    logic [2:0] pins;
    logic       cs;
    if (c == C_NOP) begin
      cs   = 1'($urandom_range(0, 1));
      pins = cs ? 3'($urandom_range(0, 7)) : 3'b111;
    end else begin
      cs   = 1'b0;
      pins = 3'(int'(c) - 1);
    end
    bus.sdr_init_done = init;
    bus.sdr_cs_n      = cs;
    {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = pins;
    bus.sdr_ba        = BA_W'(ba);
    bus.sdr_a10       = a10;
  endtask

  task automatic step(cmd_t c, int ba, bit a10, bit init);
    @(negedge sdram_clk);
    drive(c, ba, a10, init);
    model_edge(c, ba, a10, init);
    @(posedge sdram_clk);
    #1;
    chk("bank_open", bus.bank_open, e_open);
    chk("viol_valid", bus.viol_valid, e_valid);
    if (e_valid) begin
      chk("viol_code", bus.viol_code, e_code);
      chk("viol_bank", bus.viol_bank, e_bank);
    end
    chk("viol_count", bus.viol_count, m_count);
    chk("viol_count_sat", bus_sat.viol_count, m_count_sat);
  endtask

  task automatic do_reset();
    @(negedge sdram_clk);
    sdram_reset = 1'b1;
    drive(C_NOP, 0, 1'b0, 1'b0);
    repeat (2) @(posedge sdram_clk);
    #1;
    chk("rst_bank_open", bus.bank_open, 0);
    chk("rst_viol_valid", bus.viol_valid, 0);
    chk("rst_viol_code", bus.viol_code, 0);
    chk("rst_viol_bank", bus.viol_bank, 0);
    chk("rst_viol_count", bus.viol_count, 0);
    chk("rst_viol_count_sat", bus_sat.viol_count, 0);
    sdram_reset = 1'b0;
    model_reset();
  endtask

  function automatic vec_t mk(cmd_t c, int ba, bit a10, bit ev, int code, int bank,
                              logic [3:0] open);
    vec_t v;
    v.cmd = c; v.ba = ba; v.a10 = a10; v.ev = ev;
    v.ecode = code; v.ebank = bank; v.eopen = open;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   sat_exp [5] = '{1, 2, 3, 3, 3};
    int   r;
    cmd_t c;

    // Directed table: T_RCD=3, T_RP=3, T_RFC=8; init_done held at 1.
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_ACT, 2, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0100));
    vt.push_back(mk(C_ACT, 1, 0, 0, 0, 0, 4'b0100));
    vt.push_back(mk(C_RD,  1, 0, 1, 1, 1, 4'b0100));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0100));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0110));
    vt.push_back(mk(C_RD,  0, 0, 1, 2, 0, 4'b0110));
    vt.push_back(mk(C_ACT, 0, 0, 0, 0, 0, 4'b0110));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0110));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0110));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0111));
    vt.push_back(mk(C_ACT, 0, 0, 1, 3, 0, 4'b0111));
    vt.push_back(mk(C_REF, 0, 0, 1, 4, 0, 4'b0111));
    vt.push_back(mk(C_PRE, 3, 1, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_REF, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_ACT, 3, 0, 1, 1, 3, 4'b0000));
    for (int i = 0; i < 6; i++) vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_LMR, 0, 0, 1, 1, 0, 4'b0000));
    vt.push_back(mk(C_ACT, 3, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(C_NOP, 0, 0, 0, 0, 0, 4'b1000));

    model_reset();
    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].cmd, vt[i].ba, vt[i].a10, 1'b1);
      chk($sformatf("tbl%0d_open", i), bus.bank_open, vt[i].eopen);
      chk($sformatf("tbl%0d_valid", i), bus.viol_valid, vt[i].ev);
      if (vt[i].ev) begin
        chk($sformatf("tbl%0d_code", i), bus.viol_code, vt[i].ecode);
        chk($sformatf("tbl%0d_bank", i), bus.viol_bank, vt[i].ebank);
      end
    end

    // Init phase rules, then a reset that interrupts an activation timer.
    do_reset();
    step(C_ACT, 1, 1'b0, 1'b0);
    chk("init_act_code", bus.viol_code, 5);
    chk("init_act_bank", bus.viol_bank, 1);
    step(C_RD, 2, 1'b0, 1'b0);
    chk("init_rd_code", bus.viol_code, 2);
    step(C_PRE, 0, 1'b1, 1'b0);
    chk("init_pre_valid", bus.viol_valid, 0);
    step(C_LMR, 0, 1'b0, 1'b0);
    chk("init_lmr_valid", bus.viol_valid, 0);
    step(C_NOP, 0, 1'b0, 1'b1);
    step(C_ACT, 1, 1'b0, 1'b1);
    chk("run_act_valid", bus.viol_valid, 0);
    step(C_NOP, 0, 1'b0, 1'b1);
    do_reset();
    repeat (4) step(C_NOP, 0, 1'b0, 1'b1);
    chk("abort_timer_open", bus.bank_open, 0);

    // Saturating counter with a 2-bit width.
    do_reset();
    step(C_NOP, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(C_RD, 0, 1'b0, 1'b1);
      chk($sformatf("sat%0d_count", i), bus_sat.viol_count, sat_exp[i]);
      chk($sformatf("sat%0d_code", i), bus_sat.viol_code, 2);
      chk($sformatf("sat%0d_wide", i), bus.viol_count, i + 1);
    end

    // Auto-precharge on WR with a10=1.
    do_reset();
    step(C_NOP, 0, 1'b0, 1'b1);
    step(C_ACT, 2, 1'b0, 1'b1);
    repeat (3) step(C_NOP, 0, 1'b0, 1'b1);
    chk("ap_open_before", bus.bank_open, 4'b0100);
    step(C_WR, 2, 1'b1, 1'b1);
    chk("ap_wr_valid", bus.viol_valid, 0);
`ifdef SDR_MON_AUTOPRE_EN
    chk("ap_open_after", bus.bank_open[2], 0);
`else
    chk("ap_open_after", bus.bank_open[2], 1);
`endif
    repeat (3) step(C_NOP, 0, 1'b0, 1'b1);
    step(C_ACT, 2, 1'b0, 1'b1);
`ifdef SDR_MON_AUTOPRE_EN
    chk("ap_react_valid", bus.viol_valid, 0);
`else
    chk("ap_react_valid", bus.viol_valid, 1);
    chk("ap_react_code", bus.viol_code, 3);
`endif

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      r = int'($urandom_range(0, 99));
      if (r < 35)      c = C_NOP;
      else if (r < 55) c = C_ACT;
      else if (r < 65) c = C_RD;
      else if (r < 75) c = C_WR;
      else if (r < 85) c = C_PRE;
      else if (r < 89) c = C_BST;
      else if (r < 95) c = C_REF;
      else             c = C_LMR;
      step(c, int'($urandom_range(0, NB - 1)), ($urandom_range(0, 9) < 3),
           (cyc > 3) ? 1'b1 : 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
